// File: rtl/lsu_sram_if_if.sv
// lsu_sram_if_if: request/response and SRAM-side signal bundle for the LSU.
// slave = LSU front end, master = execute stage plus SRAM model.
interface lsu_sram_if_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_en;
  logic                  mem_wen;
  logic [7:0]            mem_wmask;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_wen, mem_wmask, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_wen, mem_wmask, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_sram_if.sv
// lsu_sram_if: single-outstanding LSU front end for a 1-cycle sync SRAM.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned H/HU/W accesses.
module lsu_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  lsu_sram_if_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    LOAD_WAIT,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_wen;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_req_ready;
  logic                  w_resp_valid;
  logic                  w_mem_en;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_misalign;
  logic                  w_bad;
  logic [1:0]            w_off;
  logic [3:0]            w_mask;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_ext;

  // 011 and 11x are undefined; stores have no unsigned forms
  assign w_illegal = (bus.req_funct3 == 3'b011)
                   || (bus.req_funct3[2:1] == 2'b11)
                   || (bus.req_wen && bus.req_funct3[2]);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign =
    ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
    || ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_bad    = w_illegal || w_misalign;
  assign w_accept = bus.req_valid && w_req_ready;
  assign w_off    = r_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_mem_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_req_ready = ~rst;
        if (bus.req_valid) w_next = w_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        w_mem_en = 1'b1;
        w_next   = r_wen ? RESP : LOAD_WAIT;
      end
      LOAD_WAIT: w_next = RESP;
      RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mask = 4'b0000;
    if (r_wen) begin
      unique case (r_funct3[1:0])
        2'b00:   w_mask = 4'b0001 << w_off;
        2'b01:   w_mask = 4'b0011 << w_off;
        default: w_mask = 4'b1111;
      endcase
    end
  end

  // lanes above bit 31 shift out as zero, giving the truncated half
  assign w_shift = bus.mem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_ext = bus.mem_rdata;
    unique case (r_funct3)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_ext = {24'h0, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_ext = {16'h0, w_shift[15:0]};
      default: w_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wen    <= bus.req_wen;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_rdata  <= '0;
        r_err    <= w_bad;
      end
      if (r_state == LOAD_WAIT) r_rdata <= w_ext;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  // SRAM bus is quiet outside ISSUE so reset and idle both read as zero
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_wen   = w_mem_en && r_wen;
  assign bus.mem_wmask = w_mem_en ? {4'h0, w_mask} : 8'h00;
  assign bus.mem_addr  = w_mem_en ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_wdata = w_mem_en ? (r_wdata << {w_off, 3'b000}) : '0;

endmodule

// File: tb/tb_lsu_sram_if.sv
// tb_lsu_sram_if: scoreboard bench for lsu_sram_if with a 1-cycle SRAM model.
// Honours LSU_MISALIGN_CHECK_EN to select the expected misalign behaviour.
module tb_lsu_sram_if;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lsu_sram_if_if bus ();

  lsu_sram_if dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  logic [31:0] mem [0:255];
  logic [31:0] sram_q;

  assign bus.mem_rdata = sram_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b])
            mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        sram_q <= mem[bus.mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra", 32'(bus.resp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_err", 32'(bus.resp_err), 32'(e.err));
      end
    end
  end

  task automatic run_req(
    input logic        wen,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] exp_rd,
    input logic        exp_err,
    input int          exp_lat,
    input logic [31:0] exp_ma,
    input logic [7:0]  exp_mask,
    input logic [31:0] exp_mwd,
    input int          hold
  );
    int          lat;
    int          men;
    logic        got;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [7:0]  mk;
    logic        mw;
    exp_t        e;
    @(posedge clk); #1;
    check("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.resp_ready = (hold == 0);
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; men = 0; got = 1'b0;
    ma = '0; mwd = '0; mk = '0; mw = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.mem_en) begin
        men++;
        ma  = bus.mem_addr;
        mwd = bus.mem_wdata;
        mk  = bus.mem_wmask;
        mw  = bus.mem_wen;
      end
      got = bus.resp_valid;
    end
    check("resp_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("mem_en_cnt", 32'(men), exp_err ? 32'd0 : 32'd1);
    if (!exp_err) begin
      check("mem_addr", ma, exp_ma);
      check("mem_wmask", 32'(mk), 32'(exp_mask));
      check("mem_wen", 32'(mw), 32'(wen));
      if (wen) check("mem_wdata", mwd, exp_mwd);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_wen    = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h8000_0000;
      @(negedge clk);
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_rdata", bus.resp_rdata, exp_rd);
      check("hold_err", 32'(bus.resp_err), 32'(exp_err));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_mem_en", 32'(bus.mem_en), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("post_idle_valid", 32'(bus.resp_valid), 32'd0);
    check("post_idle_mem_en", 32'(bus.mem_en), 32'd0);
  endtask

  task automatic reset_mid(input logic wen, input int cycles);
    int seen;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h8000_0300;
    bus.req_wdata  = 32'hDEAD_BEEF;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (cycles == 0) check("mid_mem_en_pre", 32'(bus.mem_en), 32'd1);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("mid_mem_en", 32'(bus.mem_en), 32'd0);
    check("mid_mem_wen", 32'(bus.mem_wen), 32'd0);
    check("mid_mem_wmask", 32'(bus.mem_wmask), 32'd0);
    check("mid_mem_addr", bus.mem_addr, 32'd0);
    check("mid_mem_wdata", bus.mem_wdata, 32'd0);
    check("mid_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_resp_rdata", bus.resp_rdata, 32'd0);
    check("mid_resp_err", 32'(bus.resp_err), 32'd0);
    check("mid_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_ready", 32'(bus.req_ready), 32'd1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_en) seen++;
    end
    check("mid_no_resp", 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          off;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
    check("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_req_ready", 32'(bus.req_ready), 32'd1);

    run_req(1, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 0, 2,
            32'h8000_0000, 8'h0F, 32'h0, 0);
    run_req(1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 2,
            32'h8000_0000, 8'h08, 32'hAB00_0000, 0);
    run_req(1, 3'b010, 32'h8000_0100, 32'h80F0_7F01, 32'h0, 0, 2,
            32'h8000_0100, 8'h0F, 32'h80F0_7F01, 0);
    run_req(0, 3'b000, 32'h8000_0102, 32'h0, 32'hFFFF_FFF0, 0, 3,
            32'h8000_0100, 8'h00, 32'h0, 0);
    run_req(0, 3'b100, 32'h8000_0102, 32'h0, 32'h0000_00F0, 0, 3,
            32'h8000_0100, 8'h00, 32'h0, 0);
    run_req(0, 3'b001, 32'h8000_0102, 32'h0, 32'hFFFF_80F0, 0, 3,
            32'h8000_0100, 8'h00, 32'h0, 0);
    run_req(0, 3'b010, 32'h8000_0100, 32'h0, 32'h80F0_7F01, 0, 3,
            32'h8000_0100, 8'h00, 32'h0, 0);
    run_req(0, 3'b100, 32'h8000_0101, 32'h0, 32'h0000_007F, 0, 3,
            32'h8000_0100, 8'h00, 32'h0, 0);
    run_req(0, 3'b010, 32'h8000_0000, 32'h0, 32'hAB00_0000, 0, 3,
            32'h8000_0000, 8'h00, 32'h0, 0);
    run_req(1, 3'b001, 32'h8000_0006, 32'hFFFF_1234, 32'h0, 0, 2,
            32'h8000_0004, 8'h0C, 32'h1234_0000, 0);
    run_req(0, 3'b101, 32'h8000_0006, 32'h0, 32'h0000_1234, 0, 3,
            32'h8000_0004, 8'h00, 32'h0, 0);
    run_req(0, 3'b001, 32'h8000_0103, 32'h0,
            MCHK ? 32'h0 : 32'h0000_0080, MCHK, MCHK ? 1 : 3,
            32'h8000_0100, 8'h00, 32'h0, 0);
    run_req(0, 3'b010, 32'h8000_0002, 32'h0,
            MCHK ? 32'h0 : 32'hAB00_0000, MCHK, MCHK ? 1 : 3,
            32'h8000_0000, 8'h00, 32'h0, 0);
    run_req(0, 3'b011, 32'h8000_0100, 32'h0, 32'h0, 1, 1,
            32'h0, 8'h00, 32'h0, 0);
    run_req(1, 3'b100, 32'h8000_0100, 32'h55, 32'h0, 1, 1,
            32'h0, 8'h00, 32'h0, 0);
    run_req(0, 3'b110, 32'h8000_0100, 32'h0, 32'h0, 1, 1,
            32'h0, 8'h00, 32'h0, 0);
    run_req(0, 3'b010, 32'h8000_0100, 32'h0, 32'h80F0_7F01, 0, 3,
            32'h8000_0100, 8'h00, 32'h0, 5);

    reset_mid(1'b1, 0);
    reset_mid(1'b0, 1);
    run_req(0, 3'b100, 32'h8000_0102, 32'h0, 32'h0000_00F0, 0, 3,
            32'h8000_0100, 8'h00, 32'h0, 0);

    for (int i = 0; i < 6; i++) begin
      d   = $urandom;
      off = i % 4;
      run_req(1, 3'b010, 32'h8000_0200 + 32'(4*i), d, 32'h0, 0, 2,
              32'h8000_0200 + 32'(4*i), 8'h0F, d, 0);
      run_req(0, 3'b010, 32'h8000_0200 + 32'(4*i), 32'h0, d, 0, 3,
              32'h8000_0200 + 32'(4*i), 8'h00, 32'h0, 0);
      run_req(0, 3'b100, 32'h8000_0200 + 32'(4*i + off), 32'h0,
              (d >> (8*off)) & 32'hFF, 0, 3,
              32'h8000_0200 + 32'(4*i), 8'h00, 32'h0, 0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
